instr_issue: RTL and testbench

- Front-end stage directly upstream of the Lab 6 controller FSM.
- Buffers 16-bit instructions in a small FIFO and loads them one at a time into the instruction register (IR).
- Decodes the IR into the controller's inputs (s, opcode, op) and the datapath's fields.
- Resolves the controller's one-hot nsel into register numbers.
- Issues the next instruction only when the controller reports idle (w=1).

---
 rtl/instr_issue_if.sv | 48 ++++
 rtl/instr_issue.sv | 162 ++++++++++++++++
 tb/tb_instr_issue.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : instr_issue_if                                               |
// | Description : Instruction-issue bus: instruction enqueue, controller       |
// |               handshake and decoded fields for the datapath.               |
// |               ISSUE_PERF_CNT_EN adds the retired/stall counter outputs.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface instr_issue_if;
   logic [15:0] in;
   logic        load;
   logic        w;
   logic [2:0]  nsel;
   logic        s;
   logic [2:0]  opcode;
   logic [1:0]  op;
   logic [1:0]  ALUop;
   logic [1:0]  shift;
   logic [15:0] sximm5;
   logic [15:0] sximm8;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        full;
   logic        empty;
   logic        overflow;
   logic        illegal;
`ifdef ISSUE_PERF_CNT_EN
   logic [15:0] retired;
   logic [15:0] stall;

   modport master (output in, load, w, nsel,
                   input  s, opcode, op, ALUop, shift, sximm5, sximm8,
                          readnum, writenum, full, empty, overflow, illegal,
                          retired, stall);
   modport slave  (input  in, load, w, nsel,
                   output s, opcode, op, ALUop, shift, sximm5, sximm8,
                          readnum, writenum, full, empty, overflow, illegal,
                          retired, stall);
`else
   modport master (output in, load, w, nsel,
                   input  s, opcode, op, ALUop, shift, sximm5, sximm8,
                          readnum, writenum, full, empty, overflow, illegal);
   modport slave  (input  in, load, w, nsel,
                   output s, opcode, op, ALUop, shift, sximm5, sximm8,
                          readnum, writenum, full, empty, overflow, illegal);
`endif
endinterface
`default_nettype wire

// File: rtl/instr_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_issue                                                  |
// | Description : Instruction FIFO + IR + decode in front of the controller    |
// |               FSM. Issues one instruction at a time while the controller   |
// |               is idle; drops instructions whose opcode is not 110/101.     |
// |               Optional macro ISSUE_PERF_CNT_EN adds retired/stall counters.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_issue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   instr_issue_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      EXEC  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [AW:0] c_full_cnt = (AW+1)'(DEPTH);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;
   logic [15:0]   r_ir;
   logic          r_overflow;
   logic          r_illegal;

   logic          w_full;
   logic          w_empty;
   logic [15:0]   w_head;
   logic          w_head_legal;
   logic          w_pop;
   logic          w_push;
   logic          w_load_ir;
   logic          w_drop;

   assign w_full       = (r_count == c_full_cnt);
   assign w_empty      = (r_count == '0);
   assign w_head       = r_mem[r_rd_ptr];
   assign w_head_legal = (w_head[15:13] == 3'b110) || (w_head[15:13] == 3'b101);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_push       = bus.load && (!w_full || w_pop);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic and pop/issue decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_load_ir   = 1'b0;
      w_drop      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!w_empty && bus.w) begin
               w_pop = 1'b1;
               if (w_head_legal) begin
                  w_load_ir   = 1'b1;
                  w_state_nxt = ISSUE;
               end else begin
                  w_drop = 1'b1;
               end
            end
         end
         ISSUE:   w_state_nxt = EXEC;
         EXEC:    if (!bus.w) w_state_nxt = DONE;
         DONE:    if (bus.w)  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FIFO storage; contents need no reset because the count gates every read.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.in;
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
         if (bus.load && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   // Instruction register and the one-cycle discard pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ir      <= 16'h0000;
         r_illegal <= 1'b0;
      end else begin
         if (w_load_ir) r_ir <= w_head;
         r_illegal <= w_drop;
      end
   end

   // Register-number select from the controller's one-hot nsel.
   always_comb begin
      bus.readnum = 3'b000;
      unique case (bus.nsel)
         3'b100:  bus.readnum = r_ir[10:8];
         3'b010:  bus.readnum = r_ir[7:5];
         3'b001:  bus.readnum = r_ir[2:0];
         default: bus.readnum = 3'b000;
      endcase
   end

   assign bus.writenum = bus.readnum;
   assign bus.s        = (r_state == ISSUE);
   assign bus.opcode   = r_ir[15:13];
   assign bus.op       = r_ir[12:11];
   assign bus.ALUop    = r_ir[12:11];
   assign bus.shift    = r_ir[4:3];
   assign bus.sximm5   = {{11{r_ir[4]}}, r_ir[4:0]};
   assign bus.sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};
   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
   assign bus.overflow = r_overflow;
   assign bus.illegal  = r_illegal;

`ifdef ISSUE_PERF_CNT_EN
   logic [15:0] r_retired;
   logic [15:0] r_stall;

   // Retired count wraps; stall count saturates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retired <= 16'h0000;
         r_stall   <= 16'h0000;
      end else begin
         if (r_state == DONE && bus.w) r_retired <= r_retired + 16'd1;
         if (r_state == IDLE && !w_empty && !bus.w && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
      end
   end

   assign bus.retired = r_retired;
   assign bus.stall   = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_issue                                               |
// | Description : Self-checking bench for instr_issue: directed scenarios then |
// |               random traffic against a queue-based reference model.        |
// |               Honours ISSUE_PERF_CNT_EN for the counter outputs.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_issue;

   localparam int DEPTH = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   instr_issue_if bus ();

   instr_issue #(.DEPTH(DEPTH), .AW(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue for the FIFO plus the controller phase
   // (0 idle, 1 issuing, 2 executing, 3 done).
   logic [15:0] q [$];
   int          m_phase;
   int          m_ir;
   logic        m_ovf;
   logic        m_ill;
   int          m_ret;
   int          m_stall;

   task automatic model_reset();
      q.delete();
      m_phase = 0;
      m_ir    = 0;
      m_ovf   = 1'b0;
      m_ill   = 1'b0;
      m_ret   = 0;
      m_stall = 0;
   endtask

   task automatic model_step(input logic [15:0] in_v, input logic load_v, input logic w_v);
      logic        pop;
      logic        was_full;
      logic [15:0] head;
      int          ph;
      ph       = m_phase;
      was_full = (q.size() == DEPTH);
      pop      = (ph == 0) && (q.size() > 0) && w_v;
      m_ill    = 1'b0;
      if (ph == 0 && q.size() > 0 && !w_v && m_stall < 65535) m_stall++;
      if (ph == 1) m_phase = 2;
      if (ph == 2 && !w_v) m_phase = 3;
      if (ph == 3 && w_v) begin
         m_phase = 0;
         m_ret   = (m_ret + 1) % 65536;
      end
      if (pop) begin
         head = q.pop_front();
         if (head[15:13] == 3'b110 || head[15:13] == 3'b101) begin
            m_ir    = int'(head);
            m_phase = 1;
         end else begin
            m_ill = 1'b1;
         end
      end
      if (load_v) begin
         if (!was_full || pop) q.push_back(in_v);
         else                  m_ovf = 1'b1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input logic [2:0] nsel_v);
      int x5, x8, rn;
      x5 = m_ir % 32;
      if (x5 >= 16) x5 = x5 + 65536 - 32;
      x8 = m_ir % 256;
      if (x8 >= 128) x8 = x8 + 65536 - 256;
      if (nsel_v == 3'b100)      rn = (m_ir / 256) % 8;
      else if (nsel_v == 3'b010) rn = (m_ir / 32) % 8;
      else if (nsel_v == 3'b001) rn = m_ir % 8;
      else                       rn = 0;
      chk("s",        bus.s,        (m_phase == 1) ? 1 : 0);
      chk("opcode",   bus.opcode,   (m_ir / 8192) % 8);
      chk("op",       bus.op,       (m_ir / 2048) % 4);
      chk("ALUop",    bus.ALUop,    (m_ir / 2048) % 4);
      chk("shift",    bus.shift,    (m_ir / 8) % 4);
      chk("sximm5",   bus.sximm5,   x5);
      chk("sximm8",   bus.sximm8,   x8);
      chk("readnum",  bus.readnum,  rn);
      chk("writenum", bus.writenum, rn);
      chk("full",     bus.full,     (q.size() == DEPTH) ? 1 : 0);
      chk("empty",    bus.empty,    (q.size() == 0) ? 1 : 0);
      chk("overflow", bus.overflow, m_ovf);
      chk("illegal",  bus.illegal,  m_ill);
`ifdef ISSUE_PERF_CNT_EN
      chk("retired",  bus.retired,  m_ret);
      chk("stall",    bus.stall,    m_stall);
`endif
   endtask

   task automatic tick(input logic [15:0] in_v, input logic load_v, input logic w_v,
                       input logic [2:0] nsel_v);
      @(negedge clk);
      bus.in   = in_v;
      bus.load = load_v;
      bus.w    = w_v;
      bus.nsel = nsel_v;
      @(posedge clk);
      model_step(in_v, load_v, w_v);
      #1;
      check_all(nsel_v);
   endtask

   // Asynchronous assertion between edges, held across one edge with load=1.
   task automatic do_reset();
      @(negedge clk);
      #1;
      reset    = 1'b0;
      bus.load = 1'b1;
      bus.in   = 16'hD1FF;
      model_reset();
      #1;
      check_all(bus.nsel);
      @(posedge clk);
      #1;
      check_all(bus.nsel);
      @(negedge clk);
      reset    = 1'b1;
      bus.load = 1'b0;
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom % 4)
         0: v[15:13] = 3'b110;
         1: v[15:13] = 3'b101;
         2: v[15:13] = 3'b111;
         default: ;
      endcase
      return v;
   endfunction

   initial begin
      #500000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       w_r;
      n_checks = 0;
      n_errors = 0;
      model_reset();
      reset    = 1'b0;
      bus.in   = 16'hD105;
      bus.load = 1'b1;
      bus.w    = 1'b1;
      bus.nsel = 3'b000;

      // Reset held with load active: nothing may enter the FIFO.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s",        bus.s,        0);
      chk("rst_empty",    bus.empty,    1);
      chk("rst_full",     bus.full,     0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_sximm8",   bus.sximm8,   0);
      check_all(bus.nsel);
      @(negedge clk);
      reset    = 1'b1;
      bus.load = 1'b0;
      tick(16'h0000, 1'b0, 1'b1, 3'b100);
      chk("rel_empty", bus.empty, 1);

      // Single MOV R1,#5.
      tick(16'hD105, 1'b1, 1'b1, 3'b100);
      chk("mov_s_early", bus.s, 0);
      tick(16'h0000, 1'b0, 1'b1, 3'b100);
      chk("mov_s",       bus.s,       1);
      chk("mov_opcode",  bus.opcode,  3'b110);
      chk("mov_op",      bus.op,      2'b10);
      chk("mov_sximm8",  bus.sximm8,  16'h0005);
      chk("mov_readnum", bus.readnum, 3'b001);
      tick(16'h0000, 1'b0, 1'b1, 3'b100);
      tick(16'h0000, 1'b0, 1'b0, 3'b100);
      tick(16'h0000, 1'b0, 1'b1, 3'b100);

      // Illegal opcode discarded, then ADD issues.
      tick(16'hE000, 1'b1, 1'b1, 3'b001);
      tick(16'hA0A1, 1'b1, 1'b1, 3'b001);
      chk("ill_pulse", bus.illegal, 1);
      chk("ill_no_s",  bus.s,       0);
      tick(16'h0000, 1'b0, 1'b1, 3'b001);
      chk("add_s",       bus.s,       1);
      chk("add_illegal", bus.illegal, 0);
      chk("add_op",      bus.op,      2'b00);
      chk("add_rm",      bus.readnum, 3'b001);
      tick(16'h0000, 1'b0, 1'b1, 3'b010);
      chk("add_rd",      bus.readnum, 3'b101);
      tick(16'h0000, 1'b0, 1'b0, 3'b010);
      tick(16'h0000, 1'b0, 1'b1, 3'b010);

      // Fill past capacity while the controller is busy, then drain.
      for (int i = 0; i < 5; i++) begin
         tick(16'hD200 + 16'(i), 1'b1, 1'b0, 3'b100);
         if (i == 3) chk("fill_full", bus.full, 1);
      end
      chk("ovf_set",  bus.overflow, 1);
      chk("ovf_full", bus.full,     1);
      for (int i = 0; i < 30; i++) tick(16'h0000, 1'b0, (i % 3) != 2, 3'b100);
      chk("drain_empty", bus.empty,    1);
      chk("ovf_sticky",  bus.overflow, 1);

      // Reset while executing with an entry still buffered.
      tick(16'hD301, 1'b1, 1'b1, 3'b100);
      tick(16'hD302, 1'b1, 1'b1, 3'b100);
      tick(16'h0000, 1'b0, 1'b1, 3'b100);
      do_reset();
      chk("mid_s",     bus.s,     0);
      chk("mid_empty", bus.empty, 1);
      tick(16'hD7FF, 1'b1, 1'b1, 3'b100);
      tick(16'h0000, 1'b0, 1'b1, 3'b100);
      chk("post_s",       bus.s,       1);
      chk("post_readnum", bus.readnum, 3'b111);
      chk("post_sximm8",  bus.sximm8,  16'hFFFF);
      tick(16'h0000, 1'b0, 1'b1, 3'b100);
      tick(16'h0000, 1'b0, 1'b0, 3'b100);
      tick(16'h0000, 1'b0, 1'b1, 3'b100);

      // Push and pop together while full.
      do_reset();
      for (int i = 0; i < 4; i++) tick(16'hB400 + 16'(i), 1'b1, 1'b0, 3'b010);
      tick(16'hB4AA, 1'b1, 1'b1, 3'b010);
      chk("pp_full",     bus.full,     1);
      chk("pp_overflow", bus.overflow, 0);
      chk("pp_s",        bus.s,        1);

      // Random traffic.
      w_r = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom % 3 == 0) w_r = ~w_r;
         if ($urandom % 150 == 0) do_reset();
         tick(rand_word(), 1'($urandom % 2), w_r, 3'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
